control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Sequencing FSM for the 16-bit bus processor. It sits directly upstream of the BusWires multiplexer.
- Decodes the instruction word latched from DIN.
- Drives the bus-source selects (Rout one-hot, Gout, DINout) plus the register/ALU load enables over a T0–T3 step sequence.
- Asserts Done when the instruction retires.

Parameters:
- DATA_W, 16, width of DIN.
- IR_W, 9, instruction width, taken from DIN[15:7] as opcode[8:6], X[5:3], Y[2:0].

Ports:
- Clock  input  1  system clock, rising edge
- Resetn  input  1  asynchronous, active-low reset
- Run  input  1  start request, sampled in T0
- DIN  input  DATA_W  instruction/immediate word from memory
- Gnz  input  1  G register non-zero flag (used only with MVNZ_EN)
- Rout  output  8  one-hot bus source select; bit7=R0 … bit0=R7
- Gout  output  1  G drives bus
- DINout  output  1  DIN drives bus
- Rin  output  8  one-hot register load enable, same bit order as Rout
- Ain  output  1  load A from bus
- Gin  output  1  load G from ALU
- AluOp  output  2  00 add, 01 sub, 10 and, 11 or
- Done  output  1  instruction complete, one-cycle pulse
- IR  output  IR_W  current instruction register (debug/observability)

Behaviour:
- Reset (Resetn=0, async):
  - step=T0, IR=0.
  - All outputs 0 combinationally until release.
- Step register: 2 bits, values T0..T3. IR register loads DIN[15:7] on the Clock edge when step=T0 and Run=1.
- Outputs are Moore-style: decoded from step and IR only.
- Source exclusivity: at most one of {any Rout bit, Gout, DINout} is asserted in any cycle. Rout is exactly one-hot or all-zero. An all-zero/idle bus select is legal.
- T0:
  - Outputs all 0.
  - If Run=1: load IR, go to T1.
  - Else stay in T0.
- Opcode 000, mv:
  - T1: Rout=Y, Rin=X, Done=1.
  - Next step T0.
- Opcode 001, mvi:
  - T1: DINout=1, Rin=X, Done=1.
  - The environment presents the immediate on DIN during T1.
  - Next step T0.
- Opcodes 010 add, 011 sub, 100 and, 101 or:
  - T1: Rout=X, Ain=1.
  - T2: Rout=Y, Gin=1, AluOp = opcode-2 (add=00, sub=01, and=10, or=11).
  - T3: Gout=1, Rin=X, Done=1.
  - Next step T0.
- Opcodes 110 and 111, illegal:
  - T1: Done=1 only, no enables.
  - Next step T0.
- Latency: mv/mvi/illegal take 2 cycles from Run sample to T0; ALU ops take 4.
- Run is ignored outside T0. Back-to-back: Run held high starts the next instruction in the T0 immediately after Done.
- X=Y is legal. Rout may hold the same value across T1/T2, and the downstream select is stable with unchanged data.
- Reset asserted mid-instruction: abort immediately. No partial Rin is issued after reset, Done is not pulsed, IR is cleared.
- AluOp is 00 whenever Gin=0.

Optional Feature:
- Macro: CU_MVNZ_EN.
- Defined:
  - Opcode 110 is mvnz (move if G non-zero).
  - T1: Rout=Y, Done=1, Rin=X only if Gnz=1.
  - Next step T0.
- Undefined: opcode 110 is illegal (Done only) and Gnz is unused.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MVNZ)
  - step encodings T0..T3
  - AluOp codes
  - the R0-at-bit7 one-hot ordering constant
- One sub-module: dec3to8_onehot. It maps a 3-bit register index to 8-bit one-hot (index 0 → 8'b1000_0000) and is instantiated for X and Y.

Test Plan:
- Reset with Run=1 and DIN=16'hFFFF, then release → step T0, all outputs 0, IR=0, no Done for 3 cycles with Run=0.
- mvi R2: DIN[15:7]=9'b001_010_000, Run=1, then DIN=16'h00A5 → T1 has DINout=1, Rin=8'b0010_0000, Done=1; next cycle all outputs 0.
- add R1,R3: IR=9'b010_001_011 →
  - T1: Rout=8'b0100_0000, Ain=1
  - T2: Rout=8'b0001_0000, Gin=1, AluOp=00
  - T3: Gout=1, Rin=8'b0100_0000, Done=1
- Run held high across mv R0,R7 then sub R4,R4 → Done pulses at cycles 2 and 6. Every cycle is checked for source exclusivity, and the sub T2 shows AluOp=01.
- Resetn pulsed low during T2 of an or → outputs 0 asynchronously, no Done, restart from T0.
- Opcode 110 with Gnz=0, then with Gnz=1 → with CU_MVNZ_EN: Rin=0 in the first case, Rin=X in the second, Done=1 in both. Without the macro: Done only in both cases.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit bus processor control path.
// Contents: opcode values, step encodings T0..T3, ALU operation codes,
// the R0-at-bit7 one-hot ordering constant and an opcode classifier.
package cpu_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Register index 0 maps to the MSB; higher indices shift toward bit 0.
  localparam logic [7:0] ONEHOT_R0 = 8'b1000_0000;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

endpackage

// File: rtl/dec3to8_onehot.sv
// 3-bit register index to 8-bit one-hot select, R0 at bit 7.
// Ports:
//   i_idx     register index 0..7
//   o_onehot  one-hot select (index 0 -> 8'b1000_0000)
module dec3to8_onehot
  import cpu_pkg::*;
(
  input  logic [2:0] i_idx,
  output logic [7:0] o_onehot
);

  assign o_onehot = ONEHOT_R0 >> i_idx;

endmodule

// File: rtl/control_unit.sv
// Sequencing FSM for the 16-bit bus processor. Latches the instruction from
// DIN in T0, then drives bus-source selects and load enables over T1..T3.
// Optional feature macro: CU_MVNZ_EN (opcode 110 becomes mvnz, uses Gnz).
// Ports:
//   Clock, Resetn          clock (rising edge), async active-low reset
//   Run                    start request, sampled in T0
//   DIN                    instruction / immediate word
//   Gnz                    G non-zero flag (mvnz only)
//   Rout, Gout, DINout     bus source selects (mutually exclusive)
//   Rin, Ain, Gin          register / A / G load enables
//   AluOp                  00 add, 01 sub, 10 and, 11 or
//   Done                   one-cycle retire pulse
//   IR                     current instruction register
//
// state | meaning
// T0    | idle, outputs 0, latch IR when Run=1
// T1    | first execute step (all opcodes)
// T2    | ALU ops: Y onto bus, load G
// T3    | ALU ops: G onto bus, load X, retire
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Gnz,
  output logic [7:0]        Rout,
  output logic              Gout,
  output logic              DINout,
  output logic [7:0]        Rin,
  output logic              Ain,
  output logic              Gin,
  output logic [1:0]        AluOp,
  output logic              Done,
  output logic [IR_W-1:0]   IR
);

  step_t           r_step;
  step_t           w_step_nxt;
  logic [IR_W-1:0] r_ir;
  logic [2:0]      w_op;
  logic [2:0]      w_x;
  logic [2:0]      w_y;
  logic [7:0]      w_x_oh;
  logic [7:0]      w_y_oh;

  logic [DATA_W-IR_W-1:0] w_din_unused;
  assign w_din_unused = DIN[DATA_W-IR_W-1:0];

`ifndef CU_MVNZ_EN
  logic w_gnz_unused;
  assign w_gnz_unused = Gnz;
`endif

  assign w_op = r_ir[8:6];
  assign w_x  = r_ir[5:3];
  assign w_y  = r_ir[2:0];
  assign IR   = r_ir;

  dec3to8_onehot u_dec_x (.i_idx(w_x), .o_onehot(w_x_oh));
  dec3to8_onehot u_dec_y (.i_idx(w_y), .o_onehot(w_y_oh));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_step <= T0;
      r_ir   <= '0;
    end else begin
      r_step <= w_step_nxt;
      if (r_step == T0 && Run) begin
        r_ir <= DIN[DATA_W-1 -: IR_W];
      end
    end
  end

  always_comb begin
    w_step_nxt = r_step;
    case (r_step)
      T0:      w_step_nxt = Run ? T1 : T0;
      T1:      w_step_nxt = is_alu_op(w_op) ? T2 : T0;
      T2:      w_step_nxt = T3;
      T3:      w_step_nxt = T0;
      default: w_step_nxt = T0;
    endcase
  end

  always_comb begin
    Rout   = '0;
    Gout   = 1'b0;
    DINout = 1'b0;
    Rin    = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AluOp  = ALU_ADD;
    Done   = 1'b0;
    case (r_step)
      T1: begin
        case (w_op)
          OP_MV: begin
            Rout = w_y_oh;
            Rin  = w_x_oh;
            Done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = w_x_oh;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Rout = w_x_oh;
            Ain  = 1'b1;
          end
`ifdef CU_MVNZ_EN
          OP_MVNZ: begin
            Rout = w_y_oh;
            Rin  = Gnz ? w_x_oh : 8'h00;
            Done = 1'b1;
          end
`endif
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        if (is_alu_op(w_op)) begin
          Rout  = w_y_oh;
          Gin   = 1'b1;
          // opcode-2 modulo 4 maps 010..101 onto 00..11
          AluOp = w_op[1:0] - 2'b10;
        end
      end
      T3: begin
        if (is_alu_op(w_op)) begin
          Gout = 1'b1;
          Rin  = w_x_oh;
          Done = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic        Gnz;
  logic [7:0]  Rout;
  logic        Gout;
  logic        DINout;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic [1:0]  AluOp;
  logic        Done;
  logic [8:0]  IR;

  control_unit #(.DATA_W(16), .IR_W(9)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .Gnz(Gnz),
    .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin), .Ain(Ain),
    .Gin(Gin), .AluOp(AluOp), .Done(Done), .IR(IR)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic [1:0] aluop;
    logic       done;
    logic [8:0] ir;
  } out_t;

  typedef struct {
    logic [8:0] ir;
    logic       gnz;
    logic [7:0] rout;
    logic [7:0] rin;
    logic       dinout;
    logic       ain;
    logic       done;
    int         len;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_q[$];
  logic [8:0] last_ir = '0;
  out_t obs_t1;
  int   obs_len;
  vec_t tbl[7];

  always @(posedge Clock) cyc <= cyc + 1;

  // Register index i selects bit (7-i).
  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] v;
    v = 8'd1;
    return v << (7 - i);
  endfunction

  function automatic int model_len(input logic [8:0] ir);
    int op;
    op = int'(ir[8:6]);
    return (op >= 2 && op <= 5) ? 3 : 1;
  endfunction

  // Expected outputs for execute step k (0 = T1) of instruction ir.
  function automatic out_t model(input logic [8:0] ir, input logic gnz, input int k);
    out_t e;
    int   op;
    e    = '0;
    e.ir = ir;
    op   = int'(ir[8:6]);
    if (op == 0) begin
      e.rout = oh(ir[2:0]); e.rin = oh(ir[5:3]); e.done = 1'b1;
    end else if (op == 1) begin
      e.dinout = 1'b1; e.rin = oh(ir[5:3]); e.done = 1'b1;
    end else if (op >= 2 && op <= 5) begin
      if (k == 0) begin
        e.rout = oh(ir[5:3]); e.ain = 1'b1;
      end else if (k == 1) begin
        e.rout = oh(ir[2:0]); e.gin = 1'b1; e.aluop = 2'(op - 2);
      end else begin
        e.gout = 1'b1; e.rin = oh(ir[5:3]); e.done = 1'b1;
      end
    end else if (op == 6) begin
`ifdef CU_MVNZ_EN
      e.rout = oh(ir[2:0]);
      e.rin  = gnz ? oh(ir[5:3]) : 8'h00;
`endif
      e.done = 1'b1;
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic out_t idle_exp(input logic [8:0] ir);
    out_t e;
    e    = '0;
    e.ir = ir;
    return e;
  endfunction

  function automatic out_t sample();
    out_t s;
    s.rout = Rout; s.gout = Gout; s.dinout = DINout; s.rin = Rin;
    s.ain = Ain; s.gin = Gin; s.aluop = AluOp; s.done = Done; s.ir = IR;
    return s;
  endfunction

  task automatic chk(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Bus-source exclusivity and AluOp idle value, every cycle.
  always @(negedge Clock) begin
    int srcs;
    srcs = $countones(Rout) + int'(Gout) + int'(DINout);
    checks++;
    if ($countones(Rout) > 1 || srcs > 1 || $countones(Rin) > 1 ||
        (!Gin && AluOp != 2'b00)) begin
      errors++;
      $display("FAIL exclusivity t=%0t got Rout=%b Gout=%b DINout=%b Rin=%b Gin=%b AluOp=%b",
               $time, Rout, Gout, DINout, Rin, Gin, AluOp);
    end
    if (Done) done_q.push_back(cyc);
  end

  // Entered and left at a negedge with the DUT in T0.
  task automatic idle();
    Run = 1'b0;
    DIN = 16'($urandom);
    @(negedge Clock);
    chk("idle_t0", sample(), idle_exp(last_ir));
  endtask

  task automatic run_instr(input logic [8:0] ir, input logic gnz, input logic hold);
    int   len;
    out_t got;
    Run = 1'b1;
    DIN = {ir, 7'($urandom)};
    Gnz = gnz;
    len = model_len(ir);
    obs_len = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge Clock);
      got = sample();
      Run = hold;
      DIN = 16'($urandom);
      if (k == 0) obs_t1 = got;
      if (got.done && obs_len == 0) obs_len = k + 1;
      chk("exec_step", got, model(ir, gnz, k));
    end
    @(negedge Clock);
    last_ir = ir;
    chk("retire_t0", sample(), idle_exp(ir));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    tbl[0] = '{9'b001_010_000, 1'b0, 8'h00, 8'b0010_0000, 1'b1, 1'b0, 1'b1, 1};
    tbl[1] = '{9'b000_000_111, 1'b0, 8'b0000_0001, 8'b1000_0000, 1'b0, 1'b0, 1'b1, 1};
    tbl[2] = '{9'b010_001_011, 1'b0, 8'b0100_0000, 8'h00, 1'b0, 1'b1, 1'b0, 3};
    tbl[3] = '{9'b011_100_100, 1'b1, 8'b0000_1000, 8'h00, 1'b0, 1'b1, 1'b0, 3};
    tbl[4] = '{9'b111_011_010, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1};
`ifdef CU_MVNZ_EN
    tbl[5] = '{9'b110_101_010, 1'b0, 8'b0010_0000, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    tbl[6] = '{9'b110_101_010, 1'b1, 8'b0010_0000, 8'b0000_0100, 1'b0, 1'b0, 1'b1, 1};
`else
    tbl[5] = '{9'b110_101_010, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    tbl[6] = '{9'b110_101_010, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1};
`endif

    // Reset with hostile inputs.
    Resetn = 1'b0; Run = 1'b1; DIN = 16'hFFFF; Gnz = 1'b0;
    repeat (3) @(negedge Clock);
    chk("in_reset", sample(), idle_exp(9'h000));
    Resetn = 1'b1; Run = 1'b0;
    repeat (3) idle();

    // Table-driven single instructions.
    for (int i = 0; i < 7; i++) begin
      run_instr(tbl[i].ir, tbl[i].gnz, 1'b0);
      chk_int("tbl_t1_rout", int'(obs_t1.rout), int'(tbl[i].rout));
      chk_int("tbl_t1_rin", int'(obs_t1.rin), int'(tbl[i].rin));
      chk_int("tbl_t1_flags", int'({obs_t1.dinout, obs_t1.ain, obs_t1.done}),
              int'({tbl[i].dinout, tbl[i].ain, tbl[i].done}));
      chk_int("tbl_done_step", obs_len, tbl[i].len);
      idle();
    end

    // Back-to-back with Run held: mv R0,R7 then sub R4,R4.
    done_q.delete();
    base = cyc;
    run_instr(9'b000_000_111, 1'b0, 1'b1);
    run_instr(9'b011_100_100, 1'b0, 1'b0);
    chk_int("b2b_done_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      chk_int("b2b_done_cycle_a", done_q[0] - base + 1, 2);
      chk_int("b2b_done_cycle_b", done_q[1] - base + 1, 6);
    end
    idle();

    // Reset during T2 of or R2,R6.
    Run = 1'b1; DIN = {9'b101_010_110, 7'd0};
    @(negedge Clock);
    Run = 1'b0;
    chk("or_t1", sample(), model(9'b101_010_110, 1'b0, 0));
    @(negedge Clock);
    chk("or_t2", sample(), model(9'b101_010_110, 1'b0, 1));
    done_q.delete();
    Resetn = 1'b0;
    #1;
    chk("async_abort", sample(), idle_exp(9'h000));
    @(negedge Clock);
    chk("abort_held", sample(), idle_exp(9'h000));
    Resetn = 1'b1;
    last_ir = '0;
    idle();
    idle();
    chk_int("abort_no_done", done_q.size(), 0);
    run_instr(9'b000_011_001, 1'b0, 1'b0);

    // Randomized instruction stream against the model.
    for (int n = 0; n < 150; n++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) idle();
      run_instr(9'($urandom), 1'($urandom), 1'($urandom));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
